sub_result_collect: RTL

Downstream collection stage for the pipelined subtractor. It tracks every operation issued into the subtractor with a valid/tag delay line matched to the subtractor's pipeline latency. It captures the difference and overflow when they emerge, derives zero, negative and overflow flags, and buffers results in a small FIFO behind a valid/ready output. Upstream issue is throttled by credits, so no result is ever dropped.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/res_fifo.sv | 51 +++++
 rtl/sub_result_collect.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared subtractor result types, default widths and flag helper
package alu_pkg;

  localparam int SUB_WIDTH    = 8;
  localparam int SUB_TAG_W    = 4;
  localparam int SUB_PIPE_LAT = 4;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } sub_flags_t;

  typedef struct packed {
    logic [SUB_WIDTH-1:0] diff;
    logic [SUB_TAG_W-1:0] tag;
    sub_flags_t           flags;
  } sub_result_t;

  // A zero difference never reports overflow.
  function automatic sub_flags_t sub_flags(input logic is_zero, input logic msb, input logic ovf);
    sub_flags_t f;
    f.zero = is_zero;
    f.neg  = msb;
    f.ovf  = ovf & ~is_zero;
    return f;
  endfunction

endpackage

// File: rtl/res_fifo.sv
// rtl/res_fifo.sv - synchronous result FIFO with occupancy count
// Head output is forced to zero while empty so idle outputs read as zero.
module res_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign w_pop = i_pop & (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/sub_result_collect.sv
// rtl/sub_result_collect.sv - credit-throttled result collector behind the pipelined subtractor
// Optional SUB_COLLECT_STICKY_EN adds clr_sticky / sticky_ovf.
module sub_result_collect
  import alu_pkg::*;
#(
  parameter int WIDTH    = SUB_WIDTH,
  parameter int PIPE_LAT = SUB_PIPE_LAT,
  parameter int DEPTH    = 4,
  parameter int TAG_W    = SUB_TAG_W
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef SUB_COLLECT_STICKY_EN
  input  logic                   clr_sticky,
  output logic                   sticky_ovf,
`endif
  input  logic                   in_valid,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       diff,
  input  logic                   ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_diff,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_zero,
  output logic                   out_neg,
  output logic                   out_ovf,
  output logic [$clog2(DEPTH):0] credits
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              FW      = WIDTH + TAG_W + 3;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [PIPE_LAT-1:0] r_v;
  logic [TAG_W-1:0]    r_tag [PIPE_LAT];
  logic [CW-1:0]       r_inflight;

  logic                w_issue;
  logic                w_capture;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_used;
  sub_flags_t          w_flags;
  sub_flags_t          w_head_flags;
  logic [FW-1:0]       w_push_data;
  logic [FW-1:0]       w_head_data;

  // Credits come from registers only, so a capture always finds a free slot.
  assign w_used    = r_inflight + w_count;
  assign in_ready  = (w_used < DEPTH_C);
  assign credits   = DEPTH_C - w_used;
  assign w_issue   = in_valid & in_ready;
  assign w_capture = r_v[PIPE_LAT-1];

  assign w_flags     = sub_flags(diff == '0, diff[WIDTH-1], ovf);
  assign w_push_data = {diff, r_tag[PIPE_LAT-1], w_flags};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_v[0]   <= w_issue;
      r_tag[0] <= in_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_v[i]   <= r_v[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase
    end
  end

  res_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_capture),
    .i_data  (w_push_data),
    .i_pop   (out_ready),
    .o_data  (w_head_data),
    .o_valid (out_valid),
    .o_count (w_count)
  );

  assign {out_diff, out_tag, w_head_flags} = w_head_data;
  assign out_zero = w_head_flags.zero;
  assign out_neg  = w_head_flags.neg;
  assign out_ovf  = w_head_flags.ovf;

`ifdef SUB_COLLECT_STICKY_EN
  logic r_sticky;
  logic w_pop;

  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sticky <= 1'b0;
    end else if (w_pop && out_ovf) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign sticky_ovf = r_sticky;
`endif

endmodule
